// File: rtl/cluster_unpacker_pkg.sv
// Shared constants and state encoding for the cluster unpacker slice.
package cluster_unpacker_pkg;

  localparam int ADR_BITS        = 11;
  localparam int CNT_BITS        = 3;
  localparam int N_STRIPS        = 1536;
  // Addresses at or above this value (including the 0x7FE/0x7FF fill codes) carry no strips.
  localparam int ADR_INVALID_MIN = N_STRIPS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/cluster_expand.sv
// Combinational expansion of one cluster word into a strip mask, clipped at the last strip.
module cluster_expand
  import cluster_unpacker_pkg::*;
#(
  parameter int MXADRBITS = ADR_BITS,
  parameter int MXCNTBITS = CNT_BITS,
  parameter int NSTRIPS   = N_STRIPS,
  parameter int ADR_LIMIT = ADR_INVALID_MIN
) (
  input  logic [MXADRBITS-1:0] adr,
  input  logic [MXCNTBITS-1:0] cnt,
  input  logic                 vpf,
  output logic [NSTRIPS-1:0]   mask,
  output logic                 adr_invalid
);

  assign adr_invalid = vpf && (int'(adr) >= ADR_LIMIT);

  // Strips past the end of the map simply fall outside the loop range.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NSTRIPS; i++) begin
      if (vpf && !adr_invalid && (i >= int'(adr)) && (i <= int'(adr) + int'(cnt)))
        mask[i] = 1'b1;
    end
  end

endmodule

// File: rtl/cluster_unpacker.sv
// Rebuilds the S-bit hit map from serialized cluster words, one frame per latch_pulse.
// Optional saturating drop counter on port errcnt when CLUSTER_UNPACKER_ERRCNT_EN is defined.
module cluster_unpacker
  import cluster_unpacker_pkg::*;
#(
  parameter int MXCLUSTERS = 8,
  parameter int MXADRBITS  = ADR_BITS,
  parameter int MXCNTBITS  = CNT_BITS,
  parameter int NSTRIPS    = N_STRIPS
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 latch_pulse,
  input  logic                                 cluster_vpf,
  input  logic [MXADRBITS-1:0]                 cluster_adr,
  input  logic [MXCNTBITS-1:0]                 cluster_cnt,
  output logic [NSTRIPS-1:0]                   vpfs_out,
  output logic                                 latch_out,
  output logic [$clog2(MXCLUSTERS+1)-1:0]      nclusters,
  output logic                                 dropped
`ifdef CLUSTER_UNPACKER_ERRCNT_EN
  ,
  output logic [7:0]                           errcnt
`endif
);

  localparam int CNTW = $clog2(MXCLUSTERS + 1);

  state_t              state, state_n;
  logic [NSTRIPS-1:0]  acc, acc_n;
  logic [CNTW-1:0]     count, count_n, count_inc;
  logic [NSTRIPS-1:0]  mask;
  logic                adr_invalid;
  logic                close, drop_n, open_frame;
  logic [NSTRIPS-1:0]  close_map;
  logic [CNTW-1:0]     close_cnt;

  cluster_expand #(
    .MXADRBITS (MXADRBITS),
    .MXCNTBITS (MXCNTBITS),
    .NSTRIPS   (NSTRIPS),
    .ADR_LIMIT (NSTRIPS)
  ) u_expand (
    .adr         (cluster_adr),
    .cnt         (cluster_cnt),
    .vpf         (cluster_vpf),
    .mask        (mask),
    .adr_invalid (adr_invalid)
  );

  assign count_inc = count + 1'b1;

  // A latch_pulse in ACCUM closes the old frame and opens the new one on the same edge.
  always_comb begin
    state_n    = state;
    acc_n      = acc;
    count_n    = count;
    close      = 1'b0;
    close_map  = acc;
    close_cnt  = count;
    drop_n     = 1'b0;
    open_frame = 1'b0;
    case (state)
      IDLE, FULL: begin
        if (latch_pulse)
          open_frame = 1'b1;
        else if (cluster_vpf)
          drop_n = 1'b1;
      end
      ACCUM: begin
        if (latch_pulse) begin
          close      = 1'b1;
          open_frame = 1'b1;
        end else if (cluster_vpf) begin
          acc_n   = acc | mask;
          count_n = count_inc;
          drop_n  = adr_invalid;
          if (count_inc == CNTW'(MXCLUSTERS)) begin
            close     = 1'b1;
            close_map = acc | mask;
            close_cnt = count_inc;
            acc_n     = '0;
            state_n   = FULL;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (open_frame) begin
      acc_n   = mask;
      count_n = CNTW'(cluster_vpf);
      drop_n  = adr_invalid;
      state_n = ACCUM;
      if (MXCLUSTERS == 1 && cluster_vpf) begin
        close     = 1'b1;
        close_map = mask;
        close_cnt = CNTW'(1);
        acc_n     = '0;
        state_n   = FULL;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      vpfs_out  <= '0;
      nclusters <= '0;
      latch_out <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      count     <= count_n;
      latch_out <= close;
      dropped   <= drop_n;
      if (close) begin
        vpfs_out  <= close_map;
        nclusters <= close_cnt;
      end
    end
  end

`ifdef CLUSTER_UNPACKER_ERRCNT_EN
  always_ff @(posedge clock) begin
    if (reset)
      errcnt <= '0;
    else if (drop_n && errcnt != 8'hFF)
      errcnt <= errcnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_cluster_unpacker.sv
// Directed, table-driven bench for cluster_unpacker (errcnt checks only with CLUSTER_UNPACKER_ERRCNT_EN).
module tb_cluster_unpacker;

  localparam int NSTRIPS = 1536;
  localparam int NCW     = 4;

  typedef struct {
    logic        lp;
    logic        vpf;
    logic [10:0] adr;
    logic [2:0]  cnt;
    logic        exp_latch;
    logic        exp_drop;
    int          exp_ncl;
    int          map_sel;
  } vec_t;

  logic               clock = 1'b0;
  logic               reset;
  logic               latch_pulse;
  logic               cluster_vpf;
  logic [10:0]        cluster_adr;
  logic [2:0]         cluster_cnt;
  logic [NSTRIPS-1:0] vpfs_out;
  logic               latch_out;
  logic [NCW-1:0]     nclusters;
  logic               dropped;
`ifdef CLUSTER_UNPACKER_ERRCNT_EN
  logic [7:0]         errcnt;
`endif

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  logic [NSTRIPS-1:0] exp_maps[7];

  cluster_unpacker #(
    .MXCLUSTERS (8),
    .MXADRBITS  (11),
    .MXCNTBITS  (3),
    .NSTRIPS    (NSTRIPS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .latch_pulse (latch_pulse),
    .cluster_vpf (cluster_vpf),
    .cluster_adr (cluster_adr),
    .cluster_cnt (cluster_cnt),
    .vpfs_out    (vpfs_out),
    .latch_out   (latch_out),
    .nclusters   (nclusters),
    .dropped     (dropped)
`ifdef CLUSTER_UNPACKER_ERRCNT_EN
    ,
    .errcnt      (errcnt)
`endif
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(logic lp, logic vpf, int adr, int cnt,
                              logic el, logic ed, int ncl, int msel);
    vec_t v;
    v.lp = lp; v.vpf = vpf; v.adr = 11'(adr); v.cnt = 3'(cnt);
    v.exp_latch = el; v.exp_drop = ed; v.exp_ncl = ncl; v.map_sel = msel;
    return v;
  endfunction

  function automatic logic [NSTRIPS-1:0] range_map(int lo, int hi);
    logic [NSTRIPS-1:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Drive one cycle of inputs, then let outputs settle just after the edge.
  task automatic applyStimulus(input logic rst, input logic lp, input logic vpf,
                               input logic [10:0] adr, input logic [2:0] cnt);
    reset       = rst;
    latch_pulse = lp;
    cluster_vpf = vpf;
    cluster_adr = adr;
    cluster_cnt = cnt;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic checkMap(input string name, input logic [NSTRIPS-1:0] exp);
    int first;
    checks++;
    if (vpfs_out !== exp) begin
      errors++;
      first = -1;
      for (int i = NSTRIPS - 1; i >= 0; i--) if (vpfs_out[i] !== exp[i]) first = i;
      $display("[TB] FAIL %s map bits set %0d expected %0d, first differing strip %0d",
               name, $countones(vpfs_out), $countones(exp), first);
    end
  endtask

  initial begin
    exp_maps[0] = '0;
    exp_maps[1] = range_map(100, 102);
    exp_maps[2] = '0;
    exp_maps[3] = '0;
    for (int k = 0; k < 8; k++) exp_maps[3] = exp_maps[3] | range_map(10 * k, 10 * k);
    exp_maps[4] = range_map(1534, 1535);
    exp_maps[5] = range_map(5, 5);
    exp_maps[6] = range_map(900, 900);

    // lp, vpf, adr, cnt, latch, drop, nclusters, map
    vecs.push_back(mk(1, 1, 100, 2, 0, 0, 0, 2));
    vecs.push_back(mk(1, 0, 0,   0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,   0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 0,   0, 1, 0, 0, 2));
    for (int k = 0; k < 7; k++) vecs.push_back(mk(0, 1, 10 * k, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 70,   0, 1, 0, 8, 3));
    vecs.push_back(mk(0, 1, 200,  0, 0, 1, 8, 3));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0, 8, 3));
    vecs.push_back(mk(1, 1, 1534, 7, 0, 0, 8, 3));
    vecs.push_back(mk(0, 1, 2047, 0, 0, 1, 8, 3));
    vecs.push_back(mk(1, 0, 0,    0, 1, 0, 2, 4));
    vecs.push_back(mk(0, 1, 5,    0, 0, 0, 2, 4));
    vecs.push_back(mk(1, 1, 900,  0, 1, 0, 1, 5));
    vecs.push_back(mk(1, 0, 0,    0, 1, 0, 1, 6));

    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("reset_latch", 32'(latch_out), 0);
    checkOutput("reset_drop", 32'(dropped), 0);
    checkOutput("reset_ncl", 32'(nclusters), 0);
    checkMap("reset_map", exp_maps[0]);
`ifdef CLUSTER_UNPACKER_ERRCNT_EN
    checkOutput("reset_errcnt", 32'(errcnt), 0);
`endif

    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].lp, vecs[i].vpf, vecs[i].adr, vecs[i].cnt);
      checkOutput($sformatf("v%0d_latch", i), 32'(latch_out), 32'(vecs[i].exp_latch));
      checkOutput($sformatf("v%0d_drop", i), 32'(dropped), 32'(vecs[i].exp_drop));
      checkOutput($sformatf("v%0d_ncl", i), 32'(nclusters), 32'(vecs[i].exp_ncl));
      if (vecs[i].map_sel != 0) checkMap($sformatf("v%0d_map", i), exp_maps[vecs[i].map_sel]);
    end

    // Reset in the middle of an accumulating frame must not emit that frame.
    applyStimulus(0, 1, 1, 300, 0);
    applyStimulus(0, 0, 1, 301, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("midreset_latch", 32'(latch_out), 0);
    checkOutput("midreset_ncl", 32'(nclusters), 0);
    checkMap("midreset_map", exp_maps[0]);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput($sformatf("midreset_idle%0d_latch", k), 32'(latch_out), 0);
    end
    applyStimulus(0, 0, 1, 50, 0);
    checkOutput("idle_word_drop", 32'(dropped), 1);
    checkMap("idle_word_map", exp_maps[0]);

`ifdef CLUSTER_UNPACKER_ERRCNT_EN
    applyStimulus(1, 0, 0, 0, 0);
    for (int k = 0; k < 300; k++) applyStimulus(0, 0, 1, 11'(k), 0);
    checkOutput("sat_drop", 32'(dropped), 1);
    checkOutput("sat_errcnt", 32'(errcnt), 255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
